// File: rtl/matmul_job_scheduler.sv
// Splits an R x C matrix product into row-major dot-product jobs and deals them round-robin
// to MAC lanes. Defining MATMUL_SCHED_PERF_EN adds the cycle_count performance counter.
module matmul_job_scheduler #(
    parameter int NUM_LANES = 2,
    parameter int DIM_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM_W-1:0]     a_rows,
    input  logic [DIM_W-1:0]     b_cols,
    input  logic [DIM_W-1:0]     inner,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NUM_LANES-1:0] job_valid,
    input  logic [NUM_LANES-1:0] job_ready,
    output logic [DIM_W-1:0]     job_row,
    output logic [DIM_W-1:0]     job_col,
    output logic [DIM_W-1:0]     job_len,
    input  logic [NUM_LANES-1:0] lane_done,
    output logic [2*DIM_W-1:0]   jobs_issued
`ifdef MATMUL_SCHED_PERF_EN
    ,
    output logic [15:0]          cycle_count
`endif
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = 2 * DIM_W;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_DISPATCH = 2'b01;
    localparam logic [1:0] ST_DRAIN    = 2'b10;
    localparam logic [1:0] ST_DONE     = 2'b11;

    logic [1:0]           state;
    logic [DIM_W-1:0]     dim_r;
    logic [DIM_W-1:0]     dim_c;
    logic [DIM_W-1:0]     row;
    logic [DIM_W-1:0]     col;
    logic [NUM_LANES-1:0] lane_busy;
    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    offer_lane;

    logic [NUM_LANES-1:0] free_mask;
    logic [LANE_W-1:0]    pick_lane;
    logic                 pick_found;
    logic [NUM_LANES-1:0] pick_onehot;
    logic [NUM_LANES-1:0] offer_onehot;
    logic [LANE_W-1:0]    rr_next;
    logic                 accept;
    logic                 last_job;
    logic                 dims_ok;

    // A lane finishing this cycle is already treated as free so it can be offered next cycle.
    assign free_mask    = ~(lane_busy & ~lane_done);
    assign pick_onehot  = NUM_LANES'(1) << pick_lane;
    assign offer_onehot = NUM_LANES'(1) << offer_lane;
    assign accept       = |(job_valid & job_ready);
    assign last_job     = (row == dim_r - DIM_W'(1)) && (col == dim_c - DIM_W'(1));
    assign dims_ok      = (a_rows != '0) && (b_cols != '0) && (inner != '0);
    assign rr_next      = (offer_lane == LANE_W'(NUM_LANES - 1)) ? '0 : offer_lane + LANE_W'(1);

    // First pass covers rr_ptr..top, second pass wraps around to the low lanes.
    always_comb begin
        pick_found = 1'b0;
        pick_lane  = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (!pick_found && free_mask[j] && (LANE_W'(j) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_lane  = LANE_W'(j);
            end
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            if (!pick_found && free_mask[j]) begin
                pick_found = 1'b1;
                pick_lane  = LANE_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            dim_r       <= '0;
            dim_c       <= '0;
            row         <= '0;
            col         <= '0;
            lane_busy   <= '0;
            rr_ptr      <= '0;
            offer_lane  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            job_valid   <= '0;
            job_row     <= '0;
            job_col     <= '0;
            job_len     <= '0;
            jobs_issued <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            lane_busy <= (lane_busy & ~lane_done) | (accept ? offer_onehot : '0);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            dim_r       <= a_rows;
                            dim_c       <= b_cols;
                            row         <= '0;
                            col         <= '0;
                            jobs_issued <= '0;
                            busy        <= 1'b1;
                            state       <= ST_DISPATCH;
                            job_row     <= '0;
                            job_col     <= '0;
                            job_len     <= inner;
                            job_valid   <= pick_found ? pick_onehot : '0;
                            offer_lane  <= pick_lane;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DISPATCH: begin
                    // An offer stays frozen until accepted; re-arbitration happens only once it is gone.
                    if (accept) begin
                        job_valid   <= '0;
                        jobs_issued <= jobs_issued + CNT_W'(1);
                        rr_ptr      <= rr_next;
                        if (col == dim_c - DIM_W'(1)) begin
                            col <= '0;
                            row <= row + DIM_W'(1);
                        end else begin
                            col <= col + DIM_W'(1);
                        end
                        if (last_job) begin
                            state <= ST_DRAIN;
                        end
                    end else if ((job_valid == '0) && pick_found) begin
                        job_valid  <= pick_onehot;
                        offer_lane <= pick_lane;
                        job_row    <= row;
                        job_col    <= col;
                    end
                end
                ST_DRAIN: begin
                    if (lane_busy == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if ((state == ST_IDLE) && start && dims_ok) begin
            cycle_count <= '0;
        end else if (((state == ST_DISPATCH) || (state == ST_DRAIN)) && (cycle_count != 16'hFFFF)) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Bench for matmul_job_scheduler: job-index reference model, per-cycle compare, directed
// scenarios with literal expectations and randomized runs. Honours MATMUL_SCHED_PERF_EN.
module tb_matmul_job_scheduler;

    localparam int NL = 2;
    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] a_rows;
    logic [DW-1:0] b_cols;
    logic [DW-1:0] inner;
    logic          busy;
    logic          done;
    logic          err;
    logic [NL-1:0] job_valid;
    logic [NL-1:0] job_ready;
    logic [DW-1:0] job_row;
    logic [DW-1:0] job_col;
    logic [DW-1:0] job_len;
    logic [NL-1:0] lane_done;
    logic [2*DW-1:0] jobs_issued;
`ifdef MATMUL_SCHED_PERF_EN
    logic [15:0]   cycle_count;
`endif

    matmul_job_scheduler #(.NUM_LANES(NL), .DIM_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a_rows(a_rows),
        .b_cols(b_cols),
        .inner(inner),
        .busy(busy),
        .done(done),
        .err(err),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_row(job_row),
        .job_col(job_col),
        .job_len(job_len),
        .lane_done(lane_done),
        .jobs_issued(jobs_issued)
`ifdef MATMUL_SCHED_PERF_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    // Reference model: progress is a count of accepted jobs, (row, col) derived by division.
    int            m_phase = 0;   // 0 idle, 1 issuing, 2 draining, 3 finishing
    int            m_R = 0, m_C = 0, m_n = 0, m_rr = 0, m_lane = 0;
    bit            m_pend = 0;
    logic [NL-1:0] m_busy = '0;
    logic          exp_busy = 0, exp_done = 0, exp_err = 0;
    logic [NL-1:0] exp_valid = '0;
    logic [DW-1:0] exp_row = '0, exp_col = '0, exp_len = '0;
    int            exp_jobs = 0;
    int            exp_cyc = 0;

    // Bench-side lane behaviour
    int            cd[NL];
    bit            ready_rand = 0, done_rand = 0, done_hold = 0, noise_en = 0, logging = 0;
    logic [NL-1:0] ready_block = '0;
    int            q_row[$], q_col[$], q_lane[$], q_len[$];
    int            busy_cycles = 0, done_pulses = 0;

    int exp_rows[4]  = '{0, 0, 1, 1};
    int exp_cols[4]  = '{0, 1, 0, 1};
    int exp_lanes[4] = '{0, 1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_offer(input logic [NL-1:0] freem);
        int l;
        l = -1;
        for (int i = 0; i < NL; i++) begin
            if (l < 0 && freem[(m_rr + i) % NL]) l = (m_rr + i) % NL;
        end
        if (l >= 0) begin
            m_pend    = 1;
            m_lane    = l;
            exp_valid = NL'(1) << l;
            exp_row   = DW'(m_n / m_C);
            exp_col   = DW'(m_n % m_C);
        end
    endtask

    task automatic model_step();
        logic          acc;
        logic [NL-1:0] nb;
        logic [NL-1:0] freem;
        if (!rst) begin
            m_phase = 0; m_rr = 0; m_n = 0; m_busy = '0; m_pend = 0; m_lane = 0;
            exp_busy = 0; exp_done = 0; exp_err = 0; exp_valid = '0;
            exp_row = '0; exp_col = '0; exp_len = '0; exp_jobs = 0; exp_cyc = 0;
        end else begin
            acc   = m_pend && job_ready[m_lane];
            nb    = m_busy & ~lane_done;
            freem = ~nb;
            if (acc) nb[m_lane] = 1'b1;
            exp_done = 0;
            exp_err  = 0;
            case (m_phase)
                0: begin
                    if (start) begin
                        if (a_rows == 0 || b_cols == 0 || inner == 0) begin
                            exp_err = 1;
                        end else begin
                            m_R = int'(a_rows); m_C = int'(b_cols); m_n = 0;
                            exp_jobs = 0; exp_cyc = 0; exp_busy = 1; exp_len = inner;
                            m_phase = 1;
                            model_offer(freem);
                        end
                    end
                end
                1: begin
                    if (exp_cyc < 65535) exp_cyc++;
                    if (acc) begin
                        m_n++;
                        exp_jobs  = m_n;
                        m_rr      = (m_lane + 1) % NL;
                        m_pend    = 0;
                        exp_valid = '0;
                        if (m_n == m_R * m_C) m_phase = 2;
                    end else if (!m_pend) begin
                        model_offer(freem);
                    end
                end
                2: begin
                    if (exp_cyc < 65535) exp_cyc++;
                    if (m_busy == '0) begin
                        m_phase  = 3;
                        exp_done = 1;
                        exp_busy = 0;
                    end
                end
                default: m_phase = 0;
            endcase
            m_busy = nb;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            chk("job_valid", 32'(job_valid), 32'(exp_valid));
            chk("job_row", 32'(job_row), 32'(exp_row));
            chk("job_col", 32'(job_col), 32'(exp_col));
            chk("job_len", 32'(job_len), 32'(exp_len));
            chk("jobs_issued", 32'(jobs_issued), 32'(exp_jobs));
`ifdef MATMUL_SCHED_PERF_EN
            chk("cycle_count", 32'(cycle_count), 32'(exp_cyc));
`endif
        end
    end

    task automatic drive_lanes();
        for (int i = 0; i < NL; i++) begin
            lane_done[i] = 1'b0;
            if (!done_hold && cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0) lane_done[i] = 1'b1;
            end else if (noise_en && cd[i] == 0 && !m_busy[i] && $urandom_range(0, 7) == 0) begin
                lane_done[i] = 1'b1;
            end
            job_ready[i] = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ready_block[i]) job_ready[i] = 1'b0;
            if (job_valid[i] && job_ready[i]) begin
                cd[i] = done_rand ? int'($urandom_range(1, 6)) : 3;
                if (logging) begin
                    q_row.push_back(int'(job_row));
                    q_col.push_back(int'(job_col));
                    q_lane.push_back(i);
                    q_len.push_back(int'(job_len));
                end
            end
        end
        if (noise_en) begin
            if (busy) begin
                start  = ($urandom_range(0, 2) == 0);
                a_rows = DW'($urandom_range(0, 15));
                b_cols = DW'($urandom_range(0, 15));
                inner  = DW'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        if (busy) busy_cycles++;
        if (done) done_pulses++;
        drive_lanes();
    endtask

    task automatic launch(input int r, input int c, input int k);
        a_rows = DW'(r);
        b_cols = DW'(c);
        inner  = DW'(k);
        busy_cycles = 0;
        done_pulses = 0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            next_cycle();
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got 0 expected 1 within %0d cycles", max_cycles);
        end
    endtask

    task automatic clear_log();
        q_row.delete();
        q_col.delete();
        q_lane.delete();
        q_len.delete();
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) cd[i] = 0;
        lane_done = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_valid"}, 32'(job_valid), 0);
        chk({tag, "_row"}, 32'(job_row), 0);
        chk({tag, "_col"}, 32'(job_col), 0);
        chk({tag, "_len"}, 32'(job_len), 0);
        chk({tag, "_jobs"}, 32'(jobs_issued), 0);
    endtask

    initial begin
        int n;
        int r, c, k;
        rst = 1'b0; start = 1'b0; a_rows = '0; b_cols = '0; inner = '0;
        job_ready = '0; lane_done = '0;
        clear_lanes();
        repeat (3) next_cycle();
        chk_all_zero("reset");
        rst = 1'b1;
        chk_en = 1;

        // Basic 2x2x2 with fixed lane latency
        clear_log();
        logging = 1;
        launch(2, 2, 2);
        wait_done(200);
        chk("basic_busy_at_done", 32'(busy), 0);
`ifdef MATMUL_SCHED_PERF_EN
        chk("basic_cycle_count", 32'(cycle_count), 32'(busy_cycles));
`endif
        repeat (3) next_cycle();
        logging = 0;
        chk("basic_jobs_issued", 32'(jobs_issued), 4);
        chk("basic_done_pulses", 32'(done_pulses), 1);
        chk("basic_busy_after", 32'(busy), 0);
        chk("basic_job_count", 32'(q_row.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_row.size()) begin
                chk("basic_row", 32'(q_row[i]), 32'(exp_rows[i]));
                chk("basic_col", 32'(q_col[i]), 32'(exp_cols[i]));
                chk("basic_lane", 32'(q_lane[i]), 32'(exp_lanes[i]));
                chk("basic_len", 32'(q_len[i]), 2);
            end
        end
`ifdef MATMUL_SCHED_PERF_EN
        chk("basic_cycle_count_hold", 32'(cycle_count), 32'(busy_cycles));
`endif

        // Zero dimension rejected
        launch(3, 0, 2);
        chk("zero_err", 32'(err), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_valid", 32'(job_valid), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            chk("zero_err_after", 32'(err), 0);
            chk("zero_valid_after", 32'(job_valid), 0);
            chk("zero_done_after", 32'(done), 0);
            chk("zero_busy_after", 32'(busy), 0);
        end

        // Backpressure on lane 0 for five cycles
        ready_block = 2'b01;
        launch(1, 3, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 32'(job_valid), 32'h1);
            chk("bp_row_hold", 32'(job_row), 0);
            chk("bp_col_hold", 32'(job_col), 0);
            chk("bp_len_hold", 32'(job_len), 4);
            if (i == 4) ready_block = 2'b00;
            next_cycle();
        end
        chk("bp_valid_c6", 32'(job_valid), 32'h1);
        chk("bp_ready_c6", 32'(job_ready[0]), 1);
        next_cycle();
        chk("bp_gap_valid", 32'(job_valid), 0);
        chk("bp_jobs_1", 32'(jobs_issued), 1);
        next_cycle();
        chk("bp_next_valid", 32'(job_valid), 32'h2);
        chk("bp_next_row", 32'(job_row), 0);
        chk("bp_next_col", 32'(job_col), 1);
        wait_done(200);
        chk("bp_jobs_end", 32'(jobs_issued), 3);
        next_cycle();

        // All lanes busy, lane_done withheld
        done_hold = 1;
        launch(2, 2, 1);
        n = 0;
        while (jobs_issued != 2 && n < 20) begin
            next_cycle();
            n++;
        end
        chk("sat_two_accepts", 32'(jobs_issued), 2);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("sat_no_offer", 32'(job_valid), 0);
        end
        lane_done = 2'b10;
        cd[1] = 0;
        next_cycle();
        chk("sat_free_valid", 32'(job_valid), 32'h2);
        chk("sat_free_row", 32'(job_row), 1);
        chk("sat_free_col", 32'(job_col), 0);
        done_hold = 0;
        wait_done(200);
        next_cycle();

        // Reset in the middle of dispatch
        launch(3, 3, 3);
        n = 0;
        while (jobs_issued != 2 && n < 50) begin
            next_cycle();
            n++;
        end
        chk("rstmid_two_jobs", 32'(jobs_issued), 2);
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        clear_lanes();
        chk_all_zero("rstmid");
        clear_log();
        logging = 1;
        launch(1, 1, 1);
        wait_done(100);
        next_cycle();
        logging = 0;
        chk("rstmid_jobs", 32'(jobs_issued), 1);
        chk("rstmid_count", 32'(q_row.size()), 1);
        if (q_row.size() > 0) begin
            chk("rstmid_row", 32'(q_row[0]), 0);
            chk("rstmid_col", 32'(q_col[0]), 0);
            chk("rstmid_lane", 32'(q_lane[0]), 0);
        end

        // Randomized runs
        ready_rand = 1;
        done_rand  = 1;
        noise_en   = 1;
        for (int t = 0; t < 30; t++) begin
            r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
            launch(r, c, k);
            if (r == 0 || c == 0 || k == 0) begin
                repeat (3) next_cycle();
            end else begin
                wait_done(500);
                repeat (2) next_cycle();
            end
        end
        noise_en = 0;
        repeat (5) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul_job_scheduler.md
Name: matmul_job_scheduler

Overview:
- Sequencer for the parallel matrix-multiply datapath. Splits an R x C result into row-major (row, col) dot-product jobs of length K.
- Dispatches the jobs round-robin to NUM_LANES MAC lanes over a valid/ready handshake and tracks per-lane completion.
- Pulses done when every result element has been computed. Sits between the top-level control/loader and the MAC lanes.

Parameters:
- NUM_LANES, 2, number of parallel MAC lanes (1..8).
- DIM_W, 4, width of each dimension; max dimension 2^DIM_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a new multiply; sampled only in IDLE.
- a_rows  in  DIM_W  rows of A (R).
- b_cols  in  DIM_W  columns of B (C).
- inner  in  DIM_W  columns of A = rows of B (K).
- busy  out  1  high in DISPATCH and DRAIN.
- done  out  1  one-cycle pulse, all jobs complete.
- err  out  1  one-cycle pulse, start rejected because a dimension is 0.
- job_valid  out  NUM_LANES  one-hot offer to a lane.
- job_ready  in  NUM_LANES  lane accepts its offer.
- job_row  out  DIM_W  row index of the offered job.
- job_col  out  DIM_W  column index of the offered job.
- job_len  out  DIM_W  dot-product length (K).
- lane_done  in  NUM_LANES  one-cycle pulse per lane, job finished.
- jobs_issued  out  2*DIM_W  count of jobs accepted since start.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; lane_busy flags, RR pointer (=lane 0), row/col counters all 0. Reset mid-operation aborts immediately; nothing is retained.
- All outputs are registered.
- IDLE:
  - start=1 with R, C, K all nonzero: latch R, C, K; row=col=0; jobs_issued=0; go to DISPATCH.
  - start=1 with any dimension 0: err=1 for one cycle; stay IDLE.
- DISPATCH:
  - One offer at a time: job_valid one-hot on the first free lane (lane_busy=0), searching from the RR pointer upward with wrap.
  - First job_valid appears in the cycle after start is sampled.
  - Once job_valid is raised, lane, job_row, job_col and job_len hold stable until job_valid & job_ready on that lane. No re-arbitration while an offer is pending.
  - On accept: lane_busy[lane]=1; jobs_issued+1; RR pointer = lane+1 mod NUM_LANES; col+1, or col=0 and row+1 when col=C-1.
  - Next offer goes out in the following cycle, so at most one accept every 2 cycles.
  - If no lane is free, job_valid=0 until a lane_done frees one. A lane freed by lane_done in cycle t is offerable from t+1.
  - After the accept of job (R-1, C-1): go to DRAIN.
- DRAIN: wait until all lane_busy=0, then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE. busy=0 from this cycle.
- lane_done edge cases:
  - Clears lane_busy in any state.
  - On a lane that is not busy: ignored.
  - Same-cycle lane_done on lane X and accept on lane Y≠X: both take effect.
- start outside IDLE is ignored.
- job_ready on a lane that has no offer is ignored.
- Total jobs = R*C, within 2*DIM_W bits.

Optional Feature:
- Macro: MATMUL_SCHED_PERF_EN.
- Defined:
  - Adds output cycle_count (out, 16 bits).
  - Cleared to 0 on the start that enters DISPATCH.
  - Increments every cycle in DISPATCH and DRAIN, saturating at 16'hFFFF.
  - Holds its value after done until the next accepted start. Reset clears it.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic 2x2, NUM_LANES=2:
  - Stimulus: R=C=K=2; job_ready tied 1; each lane_done pulses 3 cycles after its accept.
  - Response: jobs (0,0)->lane0, (0,1)->lane1, (1,0)->lane0, (1,1)->lane1; job_len=2 throughout; jobs_issued ends at 4; one done pulse; busy=0 after done.
- Zero dimension: start with R=3, C=0, K=2 -> err pulses 1 cycle; state stays IDLE; no job_valid; done stays 0.
- Backpressure:
  - Stimulus: R=1, C=3, K=4; job_ready[0] held low 5 cycles.
  - Response: job_valid=01 with row=0/col=0 stable all 5 cycles; accept on cycle 6; next offer (0,1) goes to lane1.
- Lanes saturated:
  - Stimulus: R=2, C=2; lane_done withheld.
  - Response: after 2 accepts job_valid=0. Pulse lane_done[1] -> next offer (1,0) on lane1 the following cycle.
- Reset mid-run: rst=0 for one cycle during DISPATCH after 2 jobs -> all outputs 0, IDLE. A new start with R=C=K=1 completes with a single job (0,0) on lane0 and jobs_issued=1.
- MATMUL_SCHED_PERF_EN: repeat the basic 2x2 case -> cycle_count equals the number of busy cycles measured by the bench, and holds after done.
